// File: rtl/max7219_frame_ctrl.sv
// MAX7219 sequencer: sends the init list, then refreshes 8 rows from an 8x8 buffer.
// Ports: sys_clk/_rst, enable, wr_*, intensity in; str/IRreg/data/busy driver port; status out.
module max7219_frame_ctrl #(
  parameter logic [2:0] SCAN_LIMIT     = 3'd7,
  parameter logic [3:0] INIT_INTENSITY = 4'h8,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT        = 255
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic [3:0] intensity,
  output logic       str,
  output logic [7:0] IRreg,
  output logic [7:0] data,
  input  logic       busy,
  output logic       init_done,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam logic [2:0] INIT_LOAD = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_HI   = 3'd2;
  localparam logic [2:0] WAIT_LO   = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] IDLE      = 3'd5;

  localparam logic [1:0] K_INIT = 2'd0;
  localparam logic [1:0] K_ROW  = 2'd1;
  localparam logic [1:0] K_INT  = 2'd2;

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [1:0]    kind;
  logic [2:0]    cmd_idx;
  logic [2:0]    row;
  logic [3:0]    last_int;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          retry;
  logic [7:0]    fb [8];

  logic          n_go;
  logic [1:0]    n_kind;
  logic [2:0]    n_idx;
  logic [2:0]    n_row;
  logic          n_fd;
  logic          n_initd;
  logic          bnd;
  logic [15:0]   n_cmd;
  logic [15:0]   cur_cmd;

  function automatic logic [15:0] init_cmd(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'h0C00;
      3'd1:    c = 16'h0F00;
      3'd2:    c = 16'h0900;
      3'd3:    c = {8'h0B, 5'b0, SCAN_LIMIT};
      3'd4:    c = {8'h0A, 4'b0, INIT_INTENSITY};
      default: c = 16'h0C01;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] cmd_of(
    input logic [1:0] k,
    input logic [2:0] idx,
    input logic [2:0] r,
    input logic [7:0] px,
    input logic [3:0] inten
  );
    logic [15:0] c;
    unique case (1'b1)
      (k == K_ROW): c = {4'h0, {1'b0, r} + 4'd1, px};
      (k == K_INT): c = {8'h0A, 4'h0, inten};
      default:      c = init_cmd(idx);
    endcase
    return c;
  endfunction

  // Decide what follows the command that just finished its gap (or IDLE).
  // A "boundary" is where intensity is sampled: end of init, end of
  // frame, after an intensity command, and while idle.
  always_comb begin
    n_go    = 1'b0;
    n_kind  = kind;
    n_idx   = cmd_idx;
    n_row   = row;
    n_fd    = 1'b0;
    n_initd = 1'b0;
    bnd     = 1'b0;
    if (state == IDLE) begin
      bnd = 1'b1;
    end else begin
      case (kind)
        K_INIT: begin
          if (cmd_idx == 3'd5) begin
            n_initd = 1'b1;
            bnd     = 1'b1;
          end else begin
            n_go  = 1'b1;
            n_idx = cmd_idx + 3'd1;
          end
        end
        K_ROW: begin
          if (!enable) begin
            n_row = 3'd0;
          end else if (row == 3'd7) begin
            n_fd  = 1'b1;
            n_row = 3'd0;
            bnd   = 1'b1;
          end else begin
            n_go  = 1'b1;
            n_row = row + 3'd1;
          end
        end
        default: bnd = 1'b1;
      endcase
    end
    if (bnd) begin
      if (intensity != last_int) begin
        n_go   = 1'b1;
        n_kind = K_INT;
      end else if (enable) begin
        n_go   = 1'b1;
        n_kind = K_ROW;
        n_row  = 3'd0;
      end
    end
  end

  assign n_cmd   = cmd_of(n_kind, n_idx, n_row, fb[n_row], intensity);
  assign cur_cmd = cmd_of(kind, cmd_idx, row, fb[row], intensity);

  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      state       <= INIT_LOAD;
      kind        <= K_INIT;
      cmd_idx     <= 3'd0;
      row         <= 3'd0;
      last_int    <= INIT_INTENSITY;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      retry       <= 1'b0;
      str         <= 1'b0;
      IRreg       <= 8'h00;
      data        <= 8'h00;
      init_done   <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 8; i++) fb[i] <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      if (wr_en) fb[wr_row] <= wr_data;
      case (state)
        INIT_LOAD, LOAD: begin
          {IRreg, data} <= cur_cmd;
          str           <= 1'b1;
          to_cnt        <= '0;
          state         <= WAIT_HI;
          if (kind == K_INT) last_int <= intensity;
        end
        WAIT_HI: begin
          if (busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            str         <= 1'b0;
            timeout_err <= 1'b1;
            retry       <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!busy) begin
            str     <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else if (retry) begin
            // Re-send the latched command unchanged.
            retry  <= 1'b0;
            str    <= 1'b1;
            to_cnt <= '0;
            state  <= WAIT_HI;
          end else begin
            // Launch straight from the gap so str is low exactly GAP_CYCLES.
            kind       <= n_kind;
            cmd_idx    <= n_idx;
            row        <= n_row;
            frame_done <= n_fd;
            if (n_initd) init_done <= 1'b1;
            if (n_go) begin
              {IRreg, data} <= n_cmd;
              str           <= 1'b1;
              to_cnt        <= '0;
              state         <= WAIT_HI;
              if (n_kind == K_INT) last_int <= intensity;
            end else begin
              state <= IDLE;
            end
          end
        end
        IDLE: begin
          if (n_go) begin
            kind  <= n_kind;
            row   <= n_row;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_frame_ctrl.sv
// Bench for max7219_frame_ctrl: driver model, command scoreboard, status checks.
// Covers init list, refresh, row rewrite, intensity, timeout retry, enable drop, reset.
module tb_max7219_frame_ctrl;

  logic       sys_clk;
  logic       _rst;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic [3:0] intensity;
  logic       str;
  logic [7:0] IRreg;
  logic [7:0] data;
  logic       busy;
  logic       init_done;
  logic       frame_done;
  logic       timeout_err;

  max7219_frame_ctrl dut (
    .sys_clk    (sys_clk),
    ._rst       (_rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .intensity  (intensity),
    .str        (str),
    .IRreg      (IRreg),
    .data       (data),
    .busy       (busy),
    .init_done  (init_done),
    .frame_done (frame_done),
    .timeout_err(timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_chk;
  int          n_fail;
  int          txn_cnt;
  int          fd_cnt;
  int          hi_len;
  int          lo_len;
  int          last_hi;
  logic [7:0]  last_ir;
  logic [15:0] cap;
  logic [15:0] exp_q[$];
  bit          str_q;
  bit          fd_q;
  bit          have_fall;
  bit          gap_chk;
  bit          in_rst;
  bit          block_0f;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] ir, input logic [7:0] d);
    exp_q.push_back({ir, d});
  endtask

  task automatic push_init(input bit with_retry);
    push(8'h0C, 8'h00);
    push(8'h0F, 8'h00);
    if (with_retry) push(8'h0F, 8'h00);
    push(8'h09, 8'h00);
    push(8'h0B, 8'h07);
    push(8'h0A, 8'h08);
    push(8'h0C, 8'h01);
  endtask

  task automatic push_rows(input logic [7:0] r3, input int last);
    logic [7:0] px;
    for (int r = 0; r <= last; r++) begin
      px = 8'h00;
      if (r == 0) px = 8'h81;
      if (r == 3) px = r3;
      if (r == 7) px = 8'hFF;
      push(8'(r + 1), px);
    end
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_row  = r;
    wr_data = d;
    @(negedge sys_clk);
    wr_en   = 1'b0;
  endtask

  // Driver model: busy rises ~7 cycles after str, stays 100 cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (str) begin
        if (block_0f && IRreg == 8'h0F) begin
          block_0f = 1'b0;
          while (str) @(negedge sys_clk);
        end else begin
          repeat (6) @(negedge sys_clk);
          busy = 1'b1;
          repeat (100) @(negedge sys_clk);
          busy = 1'b0;
          while (str) @(negedge sys_clk);
        end
      end
    end
  end

  // Monitor: each str rise pops one expected command.
  always @(negedge sys_clk) begin
    if (str && !str_q) begin
      txn_cnt++;
      cap = {IRreg, data};
      if (gap_chk && have_fall) chk("gap_len", lo_len, 4);
      if (exp_q.size() == 0) chk("unexpected_cmd", cap, 16'hFFFF);
      else chk("cmd", cap, exp_q.pop_front());
      hi_len = 1;
    end else if (str) begin
      hi_len++;
    end
    if (!str && str_q) begin
      if (!in_rst) begin
        chk("cmd_stable", {IRreg, data}, cap);
        have_fall = 1'b1;
      end
      last_hi = hi_len;
      last_ir = cap[15:8];
      lo_len  = 1;
    end else if (!str) begin
      lo_len++;
    end
    if (frame_done) begin
      fd_cnt++;
      chk("fd_after_row7", last_ir, 8'h08);
      chk("fd_width", fd_q, 1'b0);
    end
    str_q = str;
    fd_q  = frame_done;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int hi;
    n_chk = 0; n_fail = 0; txn_cnt = 0; fd_cnt = 0;
    hi_len = 0; lo_len = 0; last_hi = 0; last_ir = 8'h00;
    str_q = 1'b0; fd_q = 1'b0; have_fall = 1'b0;
    _rst = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_row = 3'd0;
    wr_data = 8'h00; intensity = 4'h8;
    in_rst = 1'b1; gap_chk = 1'b0; block_0f = 1'b0;
    wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'h55;
    repeat (3) @(negedge sys_clk);
    wr_en = 1'b0;
    chk("rst_str", str, 1'b0);
    chk("rst_irreg", IRreg, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);

    // Init list
    push_init(1'b0);
    gap_chk = 1'b1;
    _rst = 1'b1;
    @(negedge sys_clk);
    in_rst = 1'b0;
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge sys_clk);
    chk("init_done", init_done, 1'b1);
    chk("init_q_empty", exp_q.size(), 0);
    chk("init_txn", txn_cnt, 6);
    gap_chk = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("idle_after_init", str, 1'b0);

    // Frame A (row 2 write during reset must not show up)
    wr(3'd0, 8'h81);
    wr(3'd7, 8'hFF);
    push_rows(8'h00, 7);
    enable = 1'b1;
    for (int i = 0; i < 100 && txn_cnt < 7; i++) @(negedge sys_clk);
    chk("frame_start", txn_cnt, 7);
    gap_chk = 1'b1;
    for (int i = 0; i < 2000 && txn_cnt < 10; i++) @(negedge sys_clk);
    chk("row3_inflight", IRreg, 8'h04);
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'h11;
    @(negedge sys_clk);
    wr_data = 8'h3C;
    @(negedge sys_clk);
    wr_en = 1'b0;

    // Frame B, intensity changes collapse to one command
    push_rows(8'h3C, 7);
    for (int i = 0; i < 3000 && txn_cnt < 16; i++) @(negedge sys_clk);
    chk("frame_b_started", txn_cnt, 16);
    intensity = 4'hC;
    repeat (30) @(negedge sys_clk);
    intensity = 4'hD;
    push(8'h0A, 8'h0D);
    push_rows(8'h3C, 5);

    // Drop enable while row 5 is in flight
    for (int i = 0; i < 5000 && txn_cnt < 29; i++) @(negedge sys_clk);
    chk("fd_count_two", fd_cnt, 2);
    chk("row5_inflight", IRreg, 8'h06);
    gap_chk = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 500 && str; i++) @(negedge sys_clk);
    hi = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (str) hi++;
    end
    chk("idle_quiet", hi, 0);
    chk("idle_no_fd", fd_cnt, 2);
    chk("idle_q_empty", exp_q.size(), 0);
    chk("idle_txn", txn_cnt, 29);

    // Re-enable, then reset mid-row; init restarts with a 0F timeout
    block_0f = 1'b1;
    push(8'h01, 8'h81);
    enable = 1'b1;
    for (int i = 0; i < 200 && txn_cnt < 30; i++) @(negedge sys_clk);
    chk("reenable_row0", txn_cnt, 30);
    repeat (20) @(negedge sys_clk);
    in_rst = 1'b1;
    @(negedge sys_clk);
    _rst = 1'b0;
    enable = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_str", str, 1'b0);
    chk("mid_rst_irreg", IRreg, 8'h00);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_fd", frame_done, 1'b0);
    exp_q.delete();
    push_init(1'b1);
    push(8'h0A, 8'h0D);
    _rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    in_rst = 1'b0;
    for (int i = 0; i < 3000 && !timeout_err; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    chk("timeout_err", timeout_err, 1'b1);
    chk("timeout_hi_len", last_hi, 256);
    chk("timeout_ir", last_ir, 8'h0F);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge sys_clk);
    for (int i = 0; i < 500 && str; i++) @(negedge sys_clk);
    hi = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (str) hi++;
    end
    chk("final_quiet", hi, 0);
    chk("final_q_empty", exp_q.size(), 0);
    chk("final_init_done", init_done, 1'b1);
    chk("final_timeout_sticky", timeout_err, 1'b1);
    chk("final_txn", txn_cnt, 38);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
